// File: rtl/fosfor_present_pkg.sv
// Shared definitions for the PRESENT-80 accelerator: bus phase/command codes,
// register map addresses and the cipher's S-box, P-layer and key-schedule helpers.
package fosfor_present_pkg;

   typedef enum logic [1:0] {
      PH_IDLE = 2'b00,
      PH_CMD  = 2'b01,
      PH_LOW  = 2'b10,
      PH_HIGH = 2'b11
   } phase_e;

   localparam logic [3:0] CMD_LATCH = 4'b0001;
   localparam logic [3:0] CMD_READ  = 4'b0010;
   localparam logic [3:0] CMD_WRITE = 4'b0100;
   localparam logic [3:0] CMD_START = 4'b1000;

   localparam logic [7:0] STATE_BASE = 8'h00;
   localparam logic [7:0] TEST_ADDR  = 8'h08;
   localparam logic [7:0] KEY_BASE   = 8'h10;

   localparam int ROUNDS = 31;

   function automatic logic [3:0] sbox(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
         4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
         4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
         4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
      endcase
      return y;
   endfunction

   function automatic logic [63:0] s_layer(input logic [63:0] x);
      logic [63:0] y;
      for (int n = 0; n < 16; n++) y[4*n +: 4] = sbox(x[4*n +: 4]);
      return y;
   endfunction

   function automatic logic [63:0] p_layer(input logic [63:0] x);
      logic [63:0] y;
      y[63] = x[63];
      for (int i = 0; i < 63; i++) y[(16*i) % 63] = x[i];
      return y;
   endfunction

   // Produces the next round key from the current one and the round just used.
   function automatic logic [79:0] key_update(input logic [79:0] k, input logic [4:0] rc);
      logic [79:0] y;
      y          = {k[18:0], k[79:19]};
      y[79:76]   = sbox(y[79:76]);
      y[19:15]   = y[19:15] ^ rc;
      return y;
   endfunction

endpackage

// File: rtl/fosfor_present_core.sv
// PRESENT-80 round engine: holds the cipher state, round key and round counter,
// one round per clock, with a start/busy/done handshake and byte-wise state loads.
module fosfor_present_core
   import fosfor_present_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        wr_en,
   input  logic [2:0]  wr_idx,
   input  logic [7:0]  wr_data,
   input  logic [79:0] key,
   output logic [63:0] state,
   output logic        busy,
   output logic        done
);

   logic [63:0] state_q, state_d;
   logic [79:0] work_key_q, work_key_d;
   logic [4:0]  round_ctr_q, round_ctr_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   // round_ctr wraps from 31 to 0, which marks the final key-whitening edge.
   always_comb begin
      state_d     = state_q;
      work_key_d  = work_key_q;
      round_ctr_d = round_ctr_q;
      busy_d      = busy_q;
      done_d      = done_q;
      if (busy_q) begin
         if (round_ctr_q != 5'd0) begin
            state_d     = p_layer(s_layer(state_q ^ work_key_q[79:16]));
            work_key_d  = key_update(work_key_q, round_ctr_q);
            round_ctr_d = round_ctr_q + 5'd1;
         end else begin
            state_d = state_q ^ work_key_q[79:16];
            busy_d  = 1'b0;
            done_d  = 1'b1;
         end
      end else if (start) begin
         work_key_d  = key;
         round_ctr_d = 5'd1;
         busy_d      = 1'b1;
         done_d      = 1'b0;
      end else if (wr_en) begin
         state_d[{wr_idx, 3'b000} +: 8] = wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= '0;
         work_key_q  <= '0;
         round_ctr_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         work_key_q  <= work_key_d;
         round_ctr_q <= round_ctr_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign state = state_q;
   assign busy  = busy_q;
   assign done  = done_q;

endmodule

// File: rtl/fosfor_present.sv
// PRESENT-80 accelerator top: nibble-bus decoder, data/address registers, register map
// and output mux. Define FOSFOR_PRESENT_TEST_REG_EN to implement the scratch register at 0x08.
module fosfor_present
   import fosfor_present_pkg::*;
(
   input  logic       Clk_k,
   input  logic       Reset_rn,
   input  logic [1:0] Address_b,
   input  logic [3:0] DataIn_b,
   output logic [7:0] DataOut_b
);

   logic [7:0]  data_q, data_d;
   logic [7:0]  addr_q, addr_d;
   logic [79:0] key_q, key_d;
   logic [63:0] state;
   logic        busy, done;
   logic        start, st_wr_en;
   logic [7:0]  rd_byte;
   phase_e      phase;

   assign phase = phase_e'(Address_b);

`ifdef FOSFOR_PRESENT_TEST_REG_EN
   logic [7:0] test_q, test_d;
`endif

   always_comb begin
      rd_byte = 8'h00;
      for (int i = 0; i < 8; i++)
         if (addr_q == STATE_BASE + 8'(i)) rd_byte = state[8*i +: 8];
      for (int i = 0; i < 10; i++)
         if (addr_q == KEY_BASE + 8'(i)) rd_byte = key_q[8*i +: 8];
`ifdef FOSFOR_PRESENT_TEST_REG_EN
      if (addr_q == TEST_ADDR) rd_byte = test_q;
`endif
   end

   always_comb begin
      data_d   = data_q;
      addr_d   = addr_q;
      key_d    = key_q;
      start    = 1'b0;
      st_wr_en = 1'b0;
`ifdef FOSFOR_PRESENT_TEST_REG_EN
      test_d   = test_q;
`endif
      case (phase)
         PH_LOW:  data_d[3:0] = DataIn_b;
         PH_HIGH: data_d[7:4] = DataIn_b;
         PH_CMD: begin
            case (DataIn_b)
               CMD_LATCH: addr_d = data_q;
               CMD_READ:  data_d = rd_byte;
               CMD_WRITE: begin
                  // The core itself drops state writes while an encryption runs.
                  st_wr_en = (addr_q[7:3] == STATE_BASE[7:3]);
                  for (int i = 0; i < 10; i++)
                     if (!busy && addr_q == KEY_BASE + 8'(i)) key_d[8*i +: 8] = data_q;
`ifdef FOSFOR_PRESENT_TEST_REG_EN
                  if (addr_q == TEST_ADDR) test_d = data_q;
`endif
               end
               CMD_START: start = 1'b1;
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   always_ff @(posedge Clk_k) begin
      if (!Reset_rn) begin
         data_q <= '0;
         addr_q <= '0;
         key_q  <= '0;
      end else begin
         data_q <= data_d;
         addr_q <= addr_d;
         key_q  <= key_d;
      end
   end

`ifdef FOSFOR_PRESENT_TEST_REG_EN
   always_ff @(posedge Clk_k) begin
      if (!Reset_rn) test_q <= '0;
      else           test_q <= test_d;
   end
`endif

   fosfor_present_core u_core (
      .clk     (Clk_k),
      .rst_n   (Reset_rn),
      .start   (start),
      .wr_en   (st_wr_en),
      .wr_idx  (addr_q[2:0]),
      .wr_data (data_q),
      .key     (key_q),
      .state   (state),
      .busy    (busy),
      .done    (done)
   );

   assign DataOut_b = Address_b[1] ? data_q : {6'b0, done, ~busy};

endmodule

// File: tb/tb_fosfor_present.sv
// Randomized bench for fosfor_present against a round-by-round PRESENT-80 model.
module tb_fosfor_present;

   logic       Clk_k;
   logic       Reset_rn;
   logic [1:0] Address_b;
   logic [3:0] DataIn_b;
   logic [7:0] DataOut_b;

   int vectors;
   int miscompares;

   logic [3:0] SBOX [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                             4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

   fosfor_present dut (
      .Clk_k     (Clk_k),
      .Reset_rn  (Reset_rn),
      .Address_b (Address_b),
      .DataIn_b  (DataIn_b),
      .DataOut_b (DataOut_b)
   );

   initial Clk_k = 1'b0;
   always #5 Clk_k = ~Clk_k;

   task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] ref_present(input logic [79:0] k, input logic [63:0] pt);
      logic [63:0] s;
      logic [63:0] t;
      logic [79:0] kr;
      s  = pt;
      kr = k;
      for (int r = 1; r <= 31; r++) begin
         s = s ^ kr[79:16];
         for (int n = 0; n < 16; n++) s[4*n +: 4] = SBOX[s[4*n +: 4]];
         t = '0;
         for (int b = 0; b < 64; b++) t[(b == 63) ? 63 : (b * 16) % 63] = s[b];
         s  = t;
         kr = {kr[18:0], kr[79:19]};
         kr[79:76] = SBOX[kr[79:76]];
         kr[19:15] = kr[19:15] ^ 5'(r);
      end
      return s ^ kr[79:16];
   endfunction

   task automatic bus(input logic [1:0] ph, input logic [3:0] d);
      Address_b = ph;
      DataIn_b  = d;
      @(posedge Clk_k);
      #1;
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] v);
      bus(2'b10, a[3:0]);
      bus(2'b11, a[7:4]);
      bus(2'b01, 4'b0001);
      bus(2'b10, v[3:0]);
      bus(2'b11, v[7:4]);
      bus(2'b01, 4'b0100);
      bus(2'b00, 4'h0);
   endtask

   task automatic rd(input logic [7:0] a, output logic [7:0] v);
      bus(2'b10, a[3:0]);
      bus(2'b11, a[7:4]);
      bus(2'b01, 4'b0001);
      bus(2'b01, 4'b0010);
      Address_b = 2'b10;
      DataIn_b  = 4'h0;
      #1;
      v = DataOut_b;
   endtask

   task automatic load(input logic [79:0] k, input logic [63:0] pt);
      for (int i = 0; i < 10; i++) wr(8'h10 + 8'(i), k[8*i +: 8]);
      for (int i = 0; i < 8; i++)  wr(8'(i), pt[8*i +: 8]);
   endtask

   task automatic read_ct(output logic [63:0] ct);
      logic [7:0] b;
      for (int i = 0; i < 8; i++) begin
         rd(8'(i), b);
         ct[8*i +: 8] = b;
      end
   endtask

   task automatic wait_ready(output int c);
      c = 0;
      while (c < 40) begin
         bus(2'b00, 4'h0);
         c++;
         if (DataOut_b[0]) break;
      end
      if (!DataOut_b[0]) check("ready_timeout", {79'b0, DataOut_b[0]}, 80'd1);
   endtask

   task automatic run_enc(input string tag, input logic [79:0] k, input logic [63:0] pt,
                          input logic [63:0] exp);
      int c;
      logic [63:0] ct;
      load(k, pt);
      bus(2'b01, 4'b1000);
      bus(2'b00, 4'h0);
      check({tag, "_busy_status"}, {72'b0, DataOut_b}, 80'h00);
      wait_ready(c);
      check({tag, "_latency"}, 80'(c), 80'd31);
      check({tag, "_done_status"}, {72'b0, DataOut_b}, 80'h03);
      read_ct(ct);
      check({tag, "_ct"}, {16'b0, ct}, {16'b0, exp});
   endtask

   initial begin
      logic [7:0]  b;
      logic [79:0] k;
      logic [63:0] pt;
      logic [63:0] ct;
      int          c;
      vectors     = 0;
      miscompares = 0;
      Reset_rn    = 1'b0;
      Address_b   = 2'b00;
      DataIn_b    = 4'h0;
      repeat (3) @(posedge Clk_k);
      #1;
      Reset_rn = 1'b1;
      bus(2'b00, 4'h0);
      bus(2'b00, 4'h0);
      check("reset_status", {72'b0, DataOut_b}, 80'h01);
      Address_b = 2'b10;
      #1;
      check("reset_data_reg", {72'b0, DataOut_b}, 80'h00);

      wr(8'h08, 8'hA5);
      rd(8'h08, b);
`ifdef FOSFOR_PRESENT_TEST_REG_EN
      check("test_reg", {72'b0, b}, 80'hA5);
`else
      check("test_reg", {72'b0, b}, 80'h00);
`endif

      check("model_kat", {16'b0, ref_present('0, '0)}, {16'b0, 64'h5579C1387B228445});

      run_enc("kat_k0_p0", '0, '0, 64'h5579C1387B228445);
      run_enc("kat_k1_p0", '1, '0, 64'hE72C46C0F5945049);
      for (int i = 0; i < 10; i++) begin
         rd(8'h10 + 8'(i), b);
         check("key_readback", {72'b0, b}, 80'hFF);
      end
      run_enc("kat_k0_p1", '0, '1, 64'hA112FFC72F68417B);
      run_enc("kat_k1_p1", '1, '1, 64'h3333DCD3213210D2);

      for (int n = 0; n < 4; n++) begin
         k  = {16'($urandom), $urandom, $urandom};
         pt = {$urandom, $urandom};
         run_enc("rand", k, pt, ref_present(k, pt));
      end

      // Writes and a second START during a run must not disturb the result.
      k  = {16'($urandom), $urandom, $urandom};
      pt = {$urandom, $urandom};
      load(k, pt);
      bus(2'b01, 4'b1000);
      wr(8'h03, ~pt[31:24]);
      wr(8'h10, ~k[7:0]);
      bus(2'b01, 4'b1000);
      wait_ready(c);
      check("busy_ready", {79'b0, DataOut_b[0]}, 80'd1);
      read_ct(ct);
      check("busy_ct", {16'b0, ct}, {16'b0, ref_present(k, pt)});
      rd(8'h10, b);
      check("busy_key_write", {72'b0, b}, {72'b0, k[7:0]});

      rd(8'h20, b);
      check("unmapped_20", {72'b0, b}, 80'h00);
      rd(8'h1A, b);
      check("unmapped_1a", {72'b0, b}, 80'h00);

      load({16'($urandom), $urandom, $urandom}, {$urandom, $urandom});
      bus(2'b01, 4'b1000);
      repeat (5) bus(2'b00, 4'h0);
      check("midrun_busy", {72'b0, DataOut_b}, 80'h00);
      Reset_rn = 1'b0;
      bus(2'b00, 4'h0);
      check("midrun_reset_status", {72'b0, DataOut_b}, 80'h01);
      Reset_rn = 1'b1;
      read_ct(ct);
      check("midrun_reset_state", {16'b0, ct}, 80'h0);
      bus(2'b00, 4'h0);
      check("post_reset_status", {72'b0, DataOut_b}, 80'h01);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
